add_seq16: RTL and testbench

ADD_SEQ16 -- requirements
Module: add_seq16

---
 rtl/add_seq16_if.sv | 30 +++
 rtl/add_seq16.sv | 120 ++++++++++++
 tb/tb_add_seq16.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/add_seq16_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// add_seq16_if : operand/result bus for the nibble-serial adder.
// Rev 1.0
// ---------------------------------------------------------------------------
interface add_seq16_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         done;

  modport master (
    output start, a, b, cin,
    input  ready, sum, cout, done
  );

  modport slave (
    input  start, a, b, cin,
    output ready, sum, cout, done
  );
endinterface
`default_nettype wire

// File: rtl/add_seq16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// add_seq16 : W-bit adder built from one 4-bit ripple slice, one nibble/clock.
// Rev 1.0
// ---------------------------------------------------------------------------
module add_seq16 #(
  parameter int NIBBLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  add_seq16_if.slave bus
);
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     carry_q, carry_d;
  logic [NIBBLES-1:0][3:0]  a_q, a_d;
  logic [NIBBLES-1:0][3:0]  b_q, b_d;
  logic [NIBBLES-1:0][3:0]  sum_q, sum_d;
  logic                     cout_q, cout_d;

  logic [3:0] slice_x;
  logic [3:0] slice_y;
  logic [3:0] slice_s;
  logic [4:0] slice_c;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (idx_q == LAST_IDX) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.ready = (state_q == ST_IDLE);
    bus.done  = (state_q == ST_DONE);
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

  // The one shared slice: four chained full adders, carry-in from the register
  assign slice_c[0] = carry_q;
  generate
    for (genvar i = 0; i < 4; i++) begin : g_fa
      assign slice_s[i]   = slice_x[i] ^ slice_y[i] ^ slice_c[i];
      assign slice_c[i+1] = (slice_x[i] & slice_y[i]) |
                            (slice_x[i] & slice_c[i]) |
                            (slice_y[i] & slice_c[i]);
    end
  endgenerate

  always_comb begin
    slice_x = a_q[idx_q];
    slice_y = b_q[idx_q];
  end

  // Datapath updates
  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        sum_d[idx_q] = slice_s;
        carry_d      = slice_c[4];
        if (idx_q == LAST_IDX) begin
          cout_d = slice_c[4];
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_add_seq16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_add_seq16 : random and directed checks of add_seq16 against a + b + cin.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_add_seq16;
  logic clk = 1'b0;
  logic rst_n;
  int unsigned cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  add_seq16_if #(.NIBBLES(4)) bus  ();
  add_seq16_if #(.NIBBLES(1)) bus1 ();

  add_seq16 #(.NIBBLES(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  add_seq16 #(.NIBBLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One 16-bit operation; optionally hammers start with other operands while busy
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin, input bit junk);
    logic [16:0] expv;
    int k;
    int lat;
    bit rdy_low;
    expv = 17'(a) + 17'(b) + 17'(cin);
    k = 0;
    while (bus.ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    if (bus.ready !== 1'b1) check_val("ready_wait", 32'(bus.ready), 32'd1);
    bus.a = a; bus.b = b; bus.cin = cin; bus.start = 1'b1;
    @(negedge clk);
    bus.start = junk;
    bus.a = junk ? 16'hFFFF : 16'($urandom);
    bus.b = junk ? 16'hFFFF : 16'($urandom);
    bus.cin = 1'b1;
    rdy_low = 1'b1;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.ready !== 1'b0) rdy_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    check_val("latency", 32'(lat), 32'd4);
    check_val("sum", 32'(bus.sum), 32'(expv[15:0]));
    check_val("cout", 32'(bus.cout), 32'(expv[16]));
    check_val("ready_busy", 32'(rdy_low && bus.ready === 1'b0), 32'd1);
    bus.start = 1'b0;
    @(negedge clk);
    check_val("done_width", 32'(bus.done), 32'd0);
    check_val("ready_back", 32'(bus.ready), 32'd1);
  endtask

  task automatic run_op1(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] expv;
    int lat;
    expv = 5'(a) + 5'(b) + 5'(cin);
    bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    bus1.a = 4'($urandom); bus1.b = 4'($urandom);
    lat = 0;
    while (bus1.done !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
    check_val("n1_latency", 32'(lat), 32'd1);
    check_val("n1_sum", 32'(bus1.sum), 32'(expv[3:0]));
    check_val("n1_cout", 32'(bus1.cout), 32'(expv[4]));
    @(negedge clk);
    check_val("n1_ready_back", 32'(bus1.ready), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int k;
    int prev_stamp;
    bit saw_done;
    logic [16:0] expv;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_ready", 32'(bus.ready), 32'd1);
    check_val("rst_sum", 32'(bus.sum), 32'd0);
    check_val("rst_cout", 32'(bus.cout), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_n1_ready", 32'(bus1.ready), 32'd1);

    // start coincident with reset is discarded
    rst_n = 1'b0; bus.start = 1'b1; bus.a = 16'h0005; bus.b = 16'h0005;
    @(negedge clk);
    rst_n = 1'b1; bus.start = 1'b0;
    check_val("rst_start_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    check_val("rst_start_idle", 32'(bus.ready), 32'd1);

    run_op(16'h0001, 16'hFFFF, 1'b0, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b1, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);

    // reset sampled on E2 aborts the operation
    bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("abort_ready", 32'(bus.ready), 32'd1);
    check_val("abort_sum", 32'(bus.sum), 32'd0);
    check_val("abort_cout", 32'(bus.cout), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    check_val("abort_no_done", 32'(saw_done), 32'd0);
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);

    // start held high: one operation every NIBBLES+2 cycles
    bus.start = 1'b1;
    prev_stamp = 0;
    for (int i = 0; i < 6; i++) begin
      k = 0;
      while (bus.ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
      expv = 17'(bus.a) + 17'(bus.b) + 17'(bus.cin);
      @(negedge clk);
      k = 0;
      while (bus.done !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      check_val("b2b_sum", 32'({bus.cout, bus.sum}), 32'(expv));
      if (i > 0) check_val("b2b_period", 32'(int'(cyc) - prev_stamp), 32'd6);
      prev_stamp = int'(cyc);
      if (i == 5) bus.start = 1'b0;
    end
    @(negedge clk);

    run_op1(4'hF, 4'h1, 1'b0);
    for (int i = 0; i < 20; i++) run_op1(4'($urandom), 4'($urandom), 1'($urandom));

    for (int i = 0; i < 1000; i++) run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
